// File: rtl/reversible_pkg.sv
// Shared constants and the three self-inverse gate layers of the 8-bit
// reversible scrambler network.
package reversible_pkg;

  localparam int RL_WIDTH = 8;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_INV = 1'b1;

  // Feynman layer: upper nibble picks up the lower nibble.
  function automatic logic [7:0] layer_feynman(input logic [7:0] b);
    logic [7:0] r;
    r      = b;
    r[7:4] = b[7:4] ^ b[3:0];
    return r;
  endfunction

  // Toffoli layer: each lower bit is toggled by an adjacent pair of upper bits.
  function automatic logic [7:0] layer_toffoli(input logic [7:0] b);
    logic [7:0] r;
    r    = b;
    r[0] = b[0] ^ (b[4] & b[5]);
    r[1] = b[1] ^ (b[5] & b[6]);
    r[2] = b[2] ^ (b[6] & b[7]);
    r[3] = b[3] ^ (b[7] & b[4]);
    return r;
  endfunction

  // Fredkin layer: bit 0 controls swapping of the upper-nibble bit pairs.
  function automatic logic [7:0] layer_fredkin(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if (b[0]) begin
      r[4] = b[5];
      r[5] = b[4];
      r[6] = b[7];
      r[7] = b[6];
    end else begin
      r = b;
    end
    return r;
  endfunction

endpackage

// File: rtl/reversible_net.sv
// Combinational gate network; dir selects the forward layer order or its
// reverse, which is the exact inverse since every layer is self-inverse.
module reversible_net
  import reversible_pkg::*;
(
  input  logic       dir,
  input  logic [7:0] data,
  output logic [7:0] result
);

  logic [7:0] fwd_s;
  logic [7:0] inv_s;

  assign fwd_s = layer_fredkin(layer_toffoli(layer_feynman(data)));
  assign inv_s = layer_feynman(layer_toffoli(layer_fredkin(data)));

  // Select the network direction.
  always_comb begin
    result = fwd_s;
    case (dir)
      DIR_FWD: result = fwd_s;
      DIR_INV: result = inv_s;
      default: result = fwd_s;
    endcase
  end

endmodule

// File: rtl/reversible_logic.sv
// Reversible-gate byte scrambler with a single registered output stage.
// The output register only loads on accepted bytes, so idle-cycle data never leaks.
module reversible_logic
  import reversible_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       dir,
  input  logic [7:0] in,
  output logic [7:0] out,
  output logic       out_valid
);

  if (WIDTH != RL_WIDTH) begin : g_bad_width
    $error("reversible_logic: network is only defined for WIDTH=8");
  end

  logic [7:0] net_s;
  logic [7:0] out_r;
  logic       valid_r;

  reversible_net u_net (
    .dir    (dir),
    .data   (in),
    .result (net_s)
  );

  // Output and valid registers; reset wins over an input in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r   <= 8'h00;
      valid_r <= 1'b0;
    end else if (in_valid) begin
      out_r   <= net_s;
      valid_r <= 1'b1;
    end else begin
      out_r   <= out_r;
      valid_r <= 1'b0;
    end
  end

  assign out       = out_r;
  assign out_valid = valid_r;

endmodule

// File: tb/tb_reversible_logic.sv
// Self-checking bench for reversible_logic: directed vectors, exhaustive
// round trip and randomized traffic against a nibble-arithmetic reference.
module tb_reversible_logic;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       dir;
  logic [7:0] din;
  logic [7:0] dout;
  logic       out_valid;

  int total = 0;
  int bad   = 0;
  int fwd_tab [256];
  int inv_tab [256];
  int fo      [256];
  bit seen    [256];
  logic [7:0] exp_out;
  logic       exp_valid;

  always #5 clk = ~clk;

  reversible_logic #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .dir       (dir),
    .in        (din),
    .out       (dout),
    .out_valid (out_valid)
  );

  // Reference built from the gate rules on nibbles, not on individual wires.
  function automatic int ref_fwd(input int x);
    int hi, lo, rot;
    hi  = (x >> 4) & 15;
    lo  = x & 15;
    hi  = hi ^ lo;
    rot = ((hi >> 1) | ((hi & 1) << 3)) & 15;
    lo  = lo ^ (hi & rot);
    if ((lo & 1) != 0) hi = ((hi & 5) << 1) | ((hi >> 1) & 5);
    return (hi << 4) | lo;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive, step the reference, compare out and out_valid.
  task automatic cycle(input logic r, input logic v, input logic d, input logic [7:0] x);
    rst      = r;
    in_valid = v;
    dir      = d;
    din      = x;
    @(posedge clk);
    #1;
    if (r) begin
      exp_out   = 8'h00;
      exp_valid = 1'b0;
    end else if (v) begin
      exp_out   = d ? 8'(inv_tab[x]) : 8'(fwd_tab[x]);
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    check("out", {8'h00, dout}, {8'h00, exp_out});
    check("out_valid", {15'h0000, out_valid}, {15'h0000, exp_valid});
  endtask

  initial begin
    int distinct;
    for (int i = 0; i < 256; i++) begin
      fwd_tab[i] = ref_fwd(i);
      inv_tab[fwd_tab[i]] = i;
    end
    exp_out   = 8'h00;
    exp_valid = 1'b0;

    // Reset with a valid byte present.
    cycle(1'b1, 1'b1, 1'b0, 8'hAA);
    cycle(1'b1, 1'b1, 1'b0, 8'hAA);
    check("rst_out", {8'h00, dout}, 16'h0000);

    // Known forward vectors.
    cycle(1'b0, 1'b1, 1'b0, 8'hD2); check("fwd_D2", {8'h00, dout}, 16'h00FD);
    cycle(1'b0, 1'b1, 1'b0, 8'hF1); check("fwd_F1", {8'h00, dout}, 16'h00D7);
    cycle(1'b0, 1'b1, 1'b0, 8'h00); check("fwd_00", {8'h00, dout}, 16'h0000);
    cycle(1'b0, 1'b1, 1'b0, 8'hFF); check("fwd_FF", {8'h00, dout}, 16'h000F);

    // Inverse vectors interleaved with forward ones.
    cycle(1'b0, 1'b1, 1'b1, 8'hFD); check("inv_FD", {8'h00, dout}, 16'h00D2);
    cycle(1'b0, 1'b1, 1'b0, 8'hD2); check("alt_D2", {8'h00, dout}, 16'h00FD);
    cycle(1'b0, 1'b1, 1'b1, 8'hD7); check("inv_D7", {8'h00, dout}, 16'h00F1);
    cycle(1'b0, 1'b1, 1'b0, 8'hF1); check("alt_F1", {8'h00, dout}, 16'h00D7);
    cycle(1'b0, 1'b1, 1'b1, 8'h0F); check("inv_0F", {8'h00, dout}, 16'h00FF);

    // Bubble: output holds, valid drops, undriven data must not leak.
    cycle(1'b0, 1'b1, 1'b0, 8'hD2);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 8'hxx);
      check("bubble_hold", {8'h00, dout}, 16'h00FD);
    end

    // Exhaustive forward pass, then invert the results.
    for (int i = 0; i < 256; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'(i));
      fo[i] = int'(dout);
      seen[dout] = 1'b1;
    end
    distinct = 0;
    for (int i = 0; i < 256; i++) if (seen[i]) distinct++;
    check("distinct", 16'(distinct), 16'd256);
    for (int i = 0; i < 256; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 8'(fo[i]));
      check("roundtrip", {8'h00, dout}, 16'(i));
    end

    // Reset coinciding with a valid byte drops the byte.
    cycle(1'b0, 1'b1, 1'b0, 8'h55);
    cycle(1'b1, 1'b1, 1'b0, 8'hF1);
    check("midrst_out", {8'h00, dout}, 16'h0000);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    check("midrst_drop", {8'h00, dout}, 16'h0000);

    // Randomized traffic with occasional resets and bubbles.
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reversible_logic.md
Name: reversible_logic

Overview:
- 8-bit reversible-gate scrambler for the cryptosystem datapath: a fixed network of Feynman (CNOT), Toffoli (CCNOT) and Fredkin (CSWAP) gate layers.
- One registered stage; `dir` selects forward (encrypt) or inverse (decrypt).
- Bijective on all 256 codes; inverse(forward(x)) = x.
- Sits between the key-mixing stage and the output/transport logic.

Parameters:
- WIDTH, 8, data width; the network is defined only for 8; any other value is a synthesis-time error.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  `in`/`dir` valid this cycle.
- dir  in  1  0 = forward network, 1 = inverse network.
- in  in  8  input byte.
- out  out  8  transformed byte (registered).
- out_valid  out  1  `out` holds a result produced from the previous cycle's accepted input.

Behaviour:
- Reset, synchronous on clk when rst=1: out=8'h00, out_valid=0. rst overrides in_valid in the same cycle; an input presented during reset is dropped.
- Latency is exactly 1 clock. When in_valid=1 at edge N, out=f(in) or f⁻¹(in) and out_valid=1 after edge N. No backpressure; one byte is accepted per cycle, at full throughput.
- When in_valid=0 at an edge: out holds its last value and out_valid=0.
- `dir` is sampled with `in`. Mixing directions on consecutive cycles is legal.
- Gate layers, bit 0 = LSB. Each layer only modifies target bits; its control bits are untouched, so each layer is self-inverse.
  - L1 Feynman: b[7:4] ^= b[3:0].
  - L2 Toffoli: for i=0..3, b[i] ^= b[4+i] & b[4+((i+1) mod 4)]. Controls are from the upper nibble as entering L2.
  - L3 Fredkin: if b[0]=1, swap b[4]<->b[5] and swap b[6]<->b[7]; otherwise pass through.
- Forward f = L3(L2(L1(x))).
- Inverse f⁻¹ = L1(L2(L3(x))): same layers, reverse order.
- Layers are purely combinational. No internal state besides the output and valid registers.
- X on `in` while in_valid=0 must not propagate to `out`.

Decomposition:
- Package reversible_pkg holds:
  - RL_WIDTH=8.
  - Direction encodings DIR_FWD=1'b0 and DIR_INV=1'b1.
  - Three pure functions: layer_feynman, layer_toffoli, layer_fredkin (8-bit in, 8-bit out).
- Sub-module reversible_net: combinational, inputs dir and data, output data. It applies the layers in the order selected by dir.
- The top reversible_logic adds only the register stage, valid and reset.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1, in=8'hAA -> out=8'h00, out_valid=0 throughout.
- Forward vectors, dir=0: in=8'hD2 -> out=8'hFD one cycle later; in=8'hF1 -> out=8'hD7; 8'h00 -> 8'h00; 8'hFF -> 8'h0F. out_valid=1 each cycle.
- Inverse vectors, dir=1: 8'hFD -> 8'hD2; 8'hD7 -> 8'hF1; 8'h0F -> 8'hFF. Back-to-back issue with alternating dir; each result lands exactly one cycle after its input.
- Bubble: in_valid=0 for 3 cycles after 8'hD2 -> out stays 8'hFD, out_valid=0.
- Exhaustive: all 256 inputs forward, then feed the outputs inverse -> originals recovered; the 256 forward outputs are all distinct.
- Mid-stream reset: rst=1 in the same cycle as in_valid=1, in=8'hF1 -> next cycle out=8'h00, out_valid=0; the byte is not emitted later.
